// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port memory between the fetch and MEM stages.
// A data access is served before an instruction fetch, and the pipeline is stalled until both are done.
`default_nettype none

module pipe_mem_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_read,
    input  logic [31:0] imem_addr,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wmask,
    output logic [31:0] imem_rdata,
    output logic [31:0] dmem_rdata,
    output logic        stall_pipeline,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int                CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       imem_rdata_q, imem_rdata_d;
    logic [31:0]       dmem_rdata_q, dmem_rdata_d;
    logic              err_q, err_d;

    logic              in_acc;
    logic              expire;
    logic              acc_done;
    logic [31:0]       rdata_eff;

    // The cycle that would bring the count to MAX_WAIT without a response ends the access.
    assign in_acc    = (state_q == D_ACC) || (state_q == I_ACC);
    assign expire    = in_acc && !mem_resp && (cnt_q == CNT_LAST);
    assign acc_done  = in_acc && (mem_resp || expire);
    assign rdata_eff = mem_resp ? mem_rdata : 32'h0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        err_d        = err_q | expire;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_wmask    = 4'h0;

        case (state_q)
            IDLE: begin
                if (dmem_read || dmem_write) begin
                    state_d = D_ACC;
                end else if (imem_read) begin
                    state_d = I_ACC;
                end
            end
            D_ACC: begin
                mem_read  = dmem_read;
                mem_write = dmem_write;
                mem_addr  = dmem_addr;
                mem_wdata = dmem_wdata;
                mem_wmask = dmem_wmask;
                if (acc_done) begin
                    if (dmem_read) begin
                        dmem_rdata_d = rdata_eff;
                    end
                    state_d = imem_read ? I_ACC : DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            I_ACC: begin
                mem_read  = 1'b1;
                mem_addr  = imem_addr;
                mem_wmask = 4'hF;
                if (acc_done) begin
                    imem_rdata_d = rdata_eff;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            err_q        <= err_d;
        end
    end

    // Gated by rst_n so the pipeline is never frozen while the block is held in reset.
    assign stall_pipeline = rst_n & (imem_read | dmem_read | dmem_write) & (state_q != DONE);
    assign imem_rdata     = imem_rdata_q;
    assign dmem_rdata     = dmem_rdata_q;
    assign timeout_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed and random transactions against a transaction-level reference model.
`default_nettype none

module tb_pipe_mem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read, dmem_read, dmem_write;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        stall_pipeline;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_imem, ref_dmem;
    logic        ref_err;

    pipe_mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_addr(imem_addr),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata),
        .stall_pipeline(stall_pipeline),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory access lasting min(lat, MW) cycles; lat > MW means memory never answers.
    task automatic run_access(input bit is_d, input int lat);
        int          eff;
        logic [31:0] rd;
        eff = (lat <= MW) ? lat : MW;
        for (int c = 1; c <= eff; c++) begin
            @(posedge clk); #1;
            rd        = $urandom;
            mem_rdata = rd;
            mem_resp  = (c == lat);
            #1;
            chk(is_d ? "d_stall" : "i_stall", 32'(stall_pipeline), 32'd1);
            chk(is_d ? "d_addr" : "i_addr", mem_addr, is_d ? dmem_addr : imem_addr);
            chk(is_d ? "d_rd" : "i_rd", 32'(mem_read), is_d ? 32'(dmem_read) : 32'd1);
            chk(is_d ? "d_wr" : "i_wr", 32'(mem_write), is_d ? 32'(dmem_write) : 32'd0);
            chk(is_d ? "d_wmask" : "i_wmask", 32'(mem_wmask), is_d ? 32'(dmem_wmask) : 32'hF);
            if (is_d) chk("d_wdata", mem_wdata, dmem_wdata);
            if (c == eff) begin
                if (lat > MW) begin
                    rd      = 32'h0;
                    ref_err = 1'b1;
                end
                if (!is_d) ref_imem = rd;
                else if (dmem_read) ref_dmem = rd;
            end
        end
    endtask

    // kind: 0 none, 1 data read, 2 data write
    task automatic do_txn(input int kind, input bit ir, input logic [31:0] daddr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] iaddr, input int lat_d, input int lat_i);
        @(posedge clk); #1;
        dmem_read  = (kind == 1);
        dmem_write = (kind == 2);
        dmem_addr  = daddr;
        dmem_wdata = wdata;
        dmem_wmask = wmask;
        imem_read  = ir;
        imem_addr  = iaddr;
        #1;
        chk("idle_stall", 32'(stall_pipeline), 32'd1);
        chk("idle_memrd", 32'({mem_read, mem_write}), 32'd0);
        if (kind != 0) run_access(1'b1, lat_d);
        if (ir) run_access(1'b0, lat_i);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        #1;
        chk("done_stall", 32'(stall_pipeline), 32'd0);
        chk("done_mem", 32'({mem_read, mem_write}), 32'd0);
        chk("imem_rdata", imem_rdata, ref_imem);
        chk("dmem_rdata", dmem_rdata, ref_dmem);
        chk("timeout_err", 32'(timeout_err), 32'(ref_err));
        imem_read  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
        imem_addr = 32'h0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wmask = 4'h0;
        mem_rdata = 32'h0; mem_resp = 1'b0;
        ref_imem = 32'h0; ref_dmem = 32'h0; ref_err = 1'b0;

        #12;
        chk("rst_imem", imem_rdata, 32'h0);
        chk("rst_dmem", dmem_rdata, 32'h0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_stall", 32'(stall_pipeline), 32'd0);
        chk("rst_mem", 32'({mem_read, mem_write}), 32'd0);
        #5 rst_n = 1'b1;

        // Fetch with 2-cycle memory latency: 3 stall cycles then one release.
        do_txn(0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h60, 0, 2);
        // Simultaneous load and fetch: data side goes first.
        do_txn(1, 1'b1, 32'h100, 32'h0, 4'hF, 32'h64, 1, 3);
        // Store leaves dmem_rdata alone.
        do_txn(2, 1'b0, 32'h200, 32'hDEADBEEF, 4'b0011, 32'h0, 2, 0);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            chk("quiet_stall", 32'(stall_pipeline), 32'd0);
            chk("quiet_mem", 32'({mem_read, mem_write}), 32'd0);
        end

        // Memory never answers the fetch.
        do_txn(0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h68, 0, MW + 5);

        // Reset in the middle of a fetch.
        @(posedge clk); #1;
        imem_read = 1'b1; imem_addr = 32'h70;
        @(posedge clk); #2;
        chk("pre_rst_rd", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(mem_read), 32'd0);
        chk("mid_rst_stall", 32'(stall_pipeline), 32'd0);
        chk("mid_rst_imem", imem_rdata, 32'h0);
        chk("mid_rst_err", 32'(timeout_err), 32'd0);
        ref_imem = 32'h0; ref_dmem = 32'h0; ref_err = 1'b0;
        imem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        #1;
        chk("post_rst_rd", 32'(mem_read), 32'd0);
        chk("post_rst_imem", imem_rdata, 32'h0);
        chk("post_rst_dmem", dmem_rdata, 32'h0);

        // Response arriving exactly at the limit is a normal response.
        do_txn(1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0, MW, 0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            bit ir;
            kind = int'($urandom_range(0, 2));
            ir   = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            do_txn(kind, ir, $urandom, $urandom, 4'($urandom), $urandom,
                   int'($urandom_range(1, MW + 2)), int'($urandom_range(1, MW + 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
